// File: rtl/hdr_pkg.sv
// Shared constants and types for the HDR tone-mapping stage: sample format,
// RGB565 field layout and the FIFO word that carries a pixel plus its SOF flag.
package hdr_pkg;

   localparam int LE_W      = 8;
   localparam int LE_FP     = 4;

   localparam int R_W       = 5;
   localparam int R_OFF     = 11;
   localparam int G_W       = 6;
   localparam int G_OFF     = 5;
   localparam int B_W       = 5;
   localparam int B_OFF     = 0;
   localparam int PIX_W     = 16;

   localparam int DEF_DEPTH = 8;

   typedef struct packed {
      logic             sof;
      logic [PIX_W-1:0] rgb;
   } fifo_word_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible whenever
// the FIFO is non-empty; a write while full is accepted only if a pop frees a slot.
module sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_wr;
   logic             w_do_rd;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_do_rd = i_rd_en && !o_empty;
   assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   // Gated so the head reads as zero while empty, including straight after reset.
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/hdr_tonemap.sv
// Rescales log-irradiance triples into RGB565 using the previous frame's min/max,
// then buffers pixels in a small FIFO ahead of the frame-buffer writer.
module hdr_tonemap
   import hdr_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        hdr_done,
   input  logic [7:0]  lE_red,
   input  logic [7:0]  lE_green,
   input  logic [7:0]  lE_blue,
   output logic [15:0] pixel_out,
   output logic        pixel_sof,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        overflow
);

   function automatic logic [2:0] f_lzc(input logic [LE_W-1:0] x);
      logic [2:0] n;
      logic       hit;
      n   = '0;
      hit = 1'b0;
      for (int i = LE_W - 1; i >= 0; i--) begin
         if (!hit) begin
            if (x[i]) hit = 1'b1;
            else      n   = n + 3'd1;
         end
      end
      return n;
   endfunction

   function automatic logic [LE_W-1:0] f_clamp_sub(input logic [LE_W-1:0] a,
                                                   input logic [LE_W-1:0] m);
      return (a < m) ? '0 : (a - m);
   endfunction

   function automatic logic [LE_W-1:0] f_shift_sat(input logic [LE_W-1:0] n,
                                                   input logic [2:0]      s);
      logic [LE_W+6:0] w;
      w = {{7{1'b0}}, n} << s;
      return (|w[LE_W+6:LE_W]) ? {LE_W{1'b1}} : w[LE_W-1:0];
   endfunction

   logic [LE_W-1:0] w_le [3];
   logic [LE_W-1:0] w_min3;
   logic [LE_W-1:0] w_max3;
   logic [LE_W-1:0] w_span;
   logic [LE_W-1:0] w_span_eff;
   logic            w_seen;

   logic [LE_W-1:0] r_run_min;
   logic [LE_W-1:0] r_run_max;
   logic [LE_W-1:0] r_min_ref;
   logic [2:0]      r_shift_ref;
   logic            r_sof_pend;

   logic            r_s1_valid;
   logic            r_s1_sof;
   logic            r_s2_valid;
   logic            r_s2_sof;
   logic [2:0]      r_s2_shift;
   logic            r_overflow;

   logic [PIX_W-1:0] w_rgb;
   fifo_word_t       w_wr_word;
   fifo_word_t       w_rd_word;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;

   assign w_le[0] = lE_red;
   assign w_le[1] = lE_green;
   assign w_le[2] = lE_blue;

   always_comb begin
      w_min3 = w_le[0];
      w_max3 = w_le[0];
      for (int i = 1; i < 3; i++) begin
         if (w_le[i] < w_min3) w_min3 = w_le[i];
         if (w_le[i] > w_max3) w_max3 = w_le[i];
      end
   end

   // An empty frame leaves run_max < run_min; treat it like a flat frame (full range).
   assign w_seen     = (r_run_max >= r_run_min);
   assign w_span     = r_run_max - r_run_min;
   assign w_span_eff = (!w_seen || (w_span == '0)) ? {LE_W{1'b1}} : w_span;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_min   <= {LE_W{1'b1}};
         r_run_max   <= '0;
         r_min_ref   <= '0;
         r_shift_ref <= '0;
         r_sof_pend  <= 1'b0;
      end else begin
         if (frame_start) begin
            r_min_ref   <= w_seen ? r_run_min : '0;
            r_shift_ref <= f_lzc(w_span_eff);
            r_run_min   <= hdr_done ? w_min3 : {LE_W{1'b1}};
            r_run_max   <= hdr_done ? w_max3 : '0;
            r_sof_pend  <= !hdr_done;
         end else if (hdr_done) begin
            if (w_min3 < r_run_min) r_run_min <= w_min3;
            if (w_max3 > r_run_max) r_run_max <= w_max3;
            r_sof_pend <= 1'b0;
         end
      end
   end

   // Shift amount travels with the pixel so a later frame_start cannot re-scale it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sof   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_sof   <= 1'b0;
         r_s2_shift <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_s1_valid <= hdr_done;
         if (hdr_done) r_s1_sof <= r_sof_pend || frame_start;
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sof   <= r_s1_sof;
            r_s2_shift <= r_shift_ref;
         end
         if (r_s2_valid && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [LE_W-1:0] r_s1_le;
      logic [LE_W-1:0] r_s2_norm;
      logic [LE_W-1:0] w_v;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1_le   <= '0;
            r_s2_norm <= '0;
         end else begin
            if (hdr_done)   r_s1_le   <= w_le[gi];
            if (r_s1_valid) r_s2_norm <= f_clamp_sub(r_s1_le, r_min_ref);
         end
      end

      assign w_v = f_shift_sat(r_s2_norm, r_s2_shift);
   end

   always_comb begin
      w_rgb = '0;
      w_rgb[R_OFF +: R_W] = g_ch[0].w_v[LE_W-1 -: R_W];
      w_rgb[G_OFF +: G_W] = g_ch[1].w_v[LE_W-1 -: G_W];
      w_rgb[B_OFF +: B_W] = g_ch[2].w_v[LE_W-1 -: B_W];
   end

   assign w_wr_word.sof = r_s2_sof;
   assign w_wr_word.rgb = w_rgb;

   assign w_pop = !w_empty && pixel_ready;

   sync_fifo #(
      .WIDTH ($bits(fifo_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (r_s2_valid),
      .i_wr_data (w_wr_word),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_word),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign pixel_out   = w_rd_word.rgb;
   assign pixel_sof   = w_rd_word.sof;
   assign pixel_valid = !w_empty;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_hdr_tonemap.sv
// Directed bench for hdr_tonemap: expected {sof, rgb565} words are queued at issue
// time and a monitor pops/compares each word the DUT hands over.
module tb_hdr_tonemap;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        hdr_done;
   logic [7:0]  lE_red;
   logic [7:0]  lE_green;
   logic [7:0]  lE_blue;
   logic [15:0] pixel_out;
   logic        pixel_sof;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        overflow;

   int          n_vec = 0;
   int          n_err = 0;
   logic [16:0] exp_q [$];

   always #5 clk = ~clk;

   hdr_tonemap #(.DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .hdr_done    (hdr_done),
      .lE_red      (lE_red),
      .lE_green    (lE_green),
      .lE_blue     (lE_blue),
      .pixel_out   (pixel_out),
      .pixel_sof   (pixel_sof),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .overflow    (overflow)
   );

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic fs, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic push, input logic [16:0] e);
      frame_start = fs;
      hdr_done    = 1'b1;
      lE_red      = r;
      lE_green    = g;
      lE_blue     = b;
      if (push) exp_q.push_back(e);
      tick();
      frame_start = 1'b0;
      hdr_done    = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      repeat (4) tick();
      while ((exp_q.size() != 0 || pixel_valid) && k < 100) begin
         tick();
         k++;
      end
      check("queue_left", 17'(exp_q.size()), 17'd0);
   endtask

   // Monitor: every accepted word must match the head of the expectation queue.
   initial begin
      forever begin : mon
         logic [16:0] e;
         @(negedge clk);
         if (!rst && pixel_valid && pixel_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pixel: got 0x%0h expected none", {pixel_sof, pixel_out});
            end else begin
               e = exp_q.pop_front();
               check("pixel", {pixel_sof, pixel_out}, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst         = 1'b1;
      frame_start = 1'b0;
      hdr_done    = 1'b0;
      lE_red      = '0;
      lE_green    = '0;
      lE_blue     = '0;
      pixel_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid",    17'(pixel_valid), 17'd0);
      check("rst_out",      17'(pixel_out),   17'd0);
      check("rst_sof",      17'(pixel_sof),   17'd0);
      check("rst_overflow", 17'(overflow),    17'd0);
      rst = 1'b0;
      tick();

      // Identity mapping and first-pixel latency
      frame_start = 1'b1;
      hdr_done    = 1'b1;
      lE_red = 8'h80; lE_green = 8'h40; lE_blue = 8'hFF;
      exp_q.push_back({1'b1, 16'h821F});
      tick();
      frame_start = 1'b0;
      hdr_done    = 1'b0;
      lat = 1;
      while (!pixel_valid && lat < 10) begin
         tick();
         lat++;
      end
      check("latency", 17'(lat), 17'd3);
      drain();

      // Rescale: first frame uses refs min 0x40 / shift 0, second min 0x20 / shift 2
      pix(1'b1, 8'h20, 8'h30, 8'h40, 1'b1, {1'b1, 16'h0000});
      pix(1'b0, 8'h5F, 8'h50, 8'h30, 1'b1, {1'b0, 16'h1880});
      pix(1'b1, 8'h20, 8'h5F, 8'h40, 1'b1, {1'b1, 16'h07F0});
      pix(1'b0, 8'h70, 8'h10, 8'h20, 1'b1, {1'b0, 16'hF800});
      drain();

      // Flat frame of 0x50 then a bare frame_start (SOF carried to the next pixel)
      pix(1'b1, 8'h50, 8'h50, 8'h50, 1'b1, {1'b1, 16'h8410});
      pix(1'b0, 8'h50, 8'h50, 8'h50, 1'b1, {1'b0, 16'h8410});
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pix(1'b0, 8'h58, 8'h50, 8'h50, 1'b1, {1'b1, 16'h0800});
      drain();

      // Backpressure: 9 pixels into 8 slots; refs min 0x50, shift 4
      pixel_ready = 1'b0;
      for (int i = 0; i < 9; i++)
         pix(i == 0, 8'(8'h51 + i), 8'h50, 8'h50, i < 8, {i == 0, 16'((i + 1) << 12)});
      repeat (4) tick();
      check("bp_overflow", 17'(overflow),    17'd1);
      check("bp_valid",    17'(pixel_valid), 17'd1);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold", {pixel_sof, pixel_out}, {1'b1, 16'h1000});
         tick();
      end
      pixel_ready = 1'b1;
      drain();

      // Full FIFO with write and pop in the same cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_overflow", 17'(overflow), 17'd0);
      pixel_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         pix(1'b0, 8'(8 * (i + 1)), 8'h00, 8'h00, 1'b1, {1'b0, 16'((i + 1) << 11)});
      repeat (4) tick();
      check("full_valid", 17'(pixel_valid), 17'd1);
      pix(1'b0, 8'h48, 8'h00, 8'h00, 1'b1, {1'b0, 16'h4800});
      tick();
      pixel_ready = 1'b1;
      tick();
      pixel_ready = 1'b0;
      check("boundary_overflow", 17'(overflow), 17'd0);
      check("boundary_head", {pixel_sof, pixel_out}, {1'b0, 16'h1000});
      pixel_ready = 1'b1;
      drain();
      check("boundary_overflow_end", 17'(overflow), 17'd0);

      // Reset with 5 words queued; these must never appear
      pixel_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         pix(i == 0, 8'(8'h30 + i), 8'h20, 8'h10, 1'b0, 17'd0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("midrst_valid",    17'(pixel_valid), 17'd0);
      check("midrst_overflow", 17'(overflow),    17'd0);
      rst = 1'b0;
      pixel_ready = 1'b1;
      pix(1'b0, 8'h10, 8'h10, 8'h10, 1'b1, {1'b0, 16'h1082});
      pix(1'b1, 8'h80, 8'h40, 8'hFF, 1'b1, {1'b1, 16'h719D});
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
